// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants, SYSTEM encodings and fetch state type
package core_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0: the bubble placed in IF/ID
  localparam logic [XLEN-1:0] NOP_ENC    = 32'h0000_0013;
  localparam logic [XLEN-1:0] ECALL_ENC  = 32'h0000_0073;
  localparam logic [XLEN-1:0] EBREAK_ENC = 32'h0010_0073;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  function automatic logic is_halt_instr(input logic [XLEN-1:0] instr);
    return (instr == ECALL_ENC) || (instr == EBREAK_ENC);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
// clk, rst_n : clock, asynchronous active-low reset
// inc        : count one event this cycle
// count      : current value, sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register and halt FSM
// clk, rst_n              : clock, asynchronous active-low reset
// stall                   : hold pc and IF/ID (load-use)
// branch_taken, branch_target : EX redirect, flushes IF/ID
// imem_rdata / imem_addr  : combinational instruction memory port
// pc                      : current fetch pc
// if_id_pc/instr/valid    : IF/ID pipeline register
// halted                  : fetch stopped on ECALL/EBREAK
// stall_cnt, flush_cnt    : saturating event counters
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_ENC,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  input  logic [XLEN-1:0]   imem_rdata,
  output logic [XLEN-1:0]   imem_addr,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   if_id_pc,
  output logic [XLEN-1:0]   if_id_instr,
  output logic              if_id_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
  logic            ifid_valid_q, ifid_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;

    if (branch_taken) begin
      // an older branch also squashes any wrong-path halt
      pc_d         = {branch_target[XLEN-1:2], 2'b00};
      ifid_pc_d    = '0;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      state_d      = RUN;
    end else if (stall) begin
      // hold everything; a halt encoding seen here only counts once latched
    end else if (state_q == RUN) begin
      ifid_pc_d    = pc_q;
      ifid_instr_d = imem_rdata;
      ifid_valid_d = 1'b1;
      if (is_halt_instr(imem_rdata)) begin
        state_d = HALTED;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end else begin
      ifid_pc_d    = '0;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall && !branch_taken),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (branch_taken),
    .count (flush_cnt)
  );

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign if_id_pc    = ifid_pc_q;
  assign if_id_instr = ifid_instr_q;
  assign if_id_valid = ifid_valid_q;
  assign halted      = (state_q == HALTED);

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the 5-stage RISC-V core. It owns the PC, drives the asynchronous-read instruction memory, and registers {pc, instr, valid} into IF/ID. It consumes the load-use stall from the hazard unit and the taken-branch redirect from EX. It also halts fetch on ECALL/EBREAK and keeps saturating stall/flush event counters.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID
CNT_W, 16, width of the stall and flush event counters

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
stall  in  1  load-use stall from hazard unit: hold PC and IF/ID
branch_taken  in  1  EX-stage redirect: flush IF/ID, load branch_target
branch_target  in  32  redirect PC from EX
imem_rdata  in  32  instruction at imem_addr (combinational read)
imem_addr  out  32  equals pc
pc  out  32  current fetch PC
if_id_pc  out  32  PC of the instruction in IF/ID
if_id_instr  out  32  instruction in IF/ID
if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble)
halted  out  1  fetch is in HALTED state
stall_cnt  out  CNT_W  cycles with stall=1 and branch_taken=0, saturating
flush_cnt  out  CNT_W  cycles with branch_taken=1, saturating

Behaviour:
- Reset, asynchronous, active-low. Clock clk; reset rst_n, asynchronous, active-low. Values: pc=RESET_PC; if_id_pc=0; if_id_instr=NOP_INSTR; if_id_valid=0; state=RUN; halted=0; both counters=0. Reset asserted mid-operation takes effect immediately, regardless of stall/branch.
- Fetch is zero-latency: imem_addr=pc combinationally. The instruction appears in IF/ID one cycle after its PC is presented.
- Per-edge priority is branch_taken > stall > normal.
  - branch_taken=1: pc<=branch_target with bits[1:0] forced to 0. IF/ID<={0, NOP_INSTR, 0}. State<=RUN. flush_cnt+1. The stall input is ignored that cycle.
  - stall=1, no branch: pc and IF/ID hold all fields. stall_cnt+1.
  - Normal, state RUN: IF/ID<={pc, imem_rdata, 1}. pc<=pc+4, wrapping modulo 2^32. The exception is a SYSTEM halt encoding: imem_rdata==32'h0000_0073 (ECALL) or 32'h0010_0073 (EBREAK). In that case the instruction still enters IF/ID with valid=1, pc holds, and state<=HALTED.
  - Normal, state HALTED: pc holds. IF/ID<={0, NOP_INSTR, 0}.
- FSM:
  - States RUN, HALTED; halted=(state==HALTED).
  - RUN->HALTED on an unstalled, unredirected fetch of ECALL/EBREAK.
  - HALTED->RUN only on branch_taken, because an older branch squashes the wrong-path halt.
  - A stall in HALTED holds IF/ID.
- Counters: increment by 1 per qualifying cycle and saturate at 2^CNT_W-1, never wrapping. Both counters count in either state.
- A halt encoding fetched in a stalled cycle does not trigger HALTED until the cycle it is actually latched.

Decomposition:
- Shared package core_pkg holds XLEN=32, NOP_INSTR, ECALL/EBREAK encodings, and the fetch state enum {RUN, HALTED}.
- One sub-module: sat_counter (CNT_W, inc, count), instanced twice, for stall_cnt and flush_cnt.
- PC/IF-ID/FSM logic stays in fetch_stage.

Test Plan:
1. Reset: hold rst_n=0 mid-run, then release. Required: pc=0, if_id_valid=0, if_id_instr=0x13, halted=0, counters=0 immediately. Next edges: if_id_pc=0,4,8 with valid=1.
2. Stall: imem returns 0x00500093 at pc=8, then stall=1 for 2 cycles. Required: pc stays 0xC, IF/ID stays {8, 0x00500093, 1} for 2 cycles, stall_cnt=2. On release, pc=0x10.
3. Branch beats stall: stall=1 and branch_taken=1 with target 0x103 in the same cycle. Required: pc=0x100, IF/ID={0, 0x13, 0}, flush_cnt=1, stall_cnt unchanged.
4. Halt: imem returns 0x00100073 at pc=0x20. Required: IF/ID={0x20, 0x00100073, 1}, pc stays 0x20, halted=1. Subsequent IF/ID entries are bubbles. branch_taken to 0x40 gives halted=0 and pc=0x40.
5. Halt under stall: ECALL present at pc while stall=1 for 1 cycle. Required: halted stays 0 during the stall cycle and becomes 1 on the next unstalled edge.
6. Saturation (CNT_W=2): 5 stall cycles give stall_cnt=3. PC wrap: pc=0xFFFF_FFFC with a normal fetch gives pc=0.
